// File: rtl/fp32_div.sv
// Iterative IEEE-754 single-precision divider (a / b) with RISC-V rounding modes.
// Restoring shift-subtract core, one operation in flight, valid/ready on both sides.
module fp32_div #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        nv,
    output logic        dz,
    output logic        of,
    output logic        uf,
    output logic        nx
);
    localparam int unsigned DIV_CYCLES = 27 / BITS_PER_CYCLE;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    logic [2:0]         state, state_nxt;
    logic [31:0]        a_r, b_r;
    logic [2:0]         rm_r;
    logic               sign;
    logic signed [9:0]  exp_q;
    logic [23:0]        mb;
    logic [24:0]        rem, rem_n;
    logic [26:0]        q, q_n;
    logic [4:0]         cnt;
    logic               spec, spec_nv, spec_dz;
    logic [31:0]        spec_res;

    function automatic logic [4:0] lzc24(input logic [23:0] x);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++)
            if (x[i]) n = 5'(23 - i);
        return n;
    endfunction

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_PREP;
            S_PREP:  state_nxt = S_DIV;
            S_DIV:   if (cnt == 5'(DIV_CYCLES - 1)) state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand classification and subnormal normalisation
    logic [7:0]        a_exp, b_exp;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [23:0]       man_a, man_b;
    logic [4:0]        lz_a, lz_b;
    logic signed [9:0] ea, eb;
    logic              spec_n, spec_nv_n, spec_dz_n;
    logic [31:0]       spec_res_n;
    logic              sign_n;

    always_comb begin
        a_exp  = a_r[30:23];
        b_exp  = b_r[30:23];
        a_zero = (a_exp == 8'd0) && (a_r[22:0] == 23'd0);
        b_zero = (b_exp == 8'd0) && (b_r[22:0] == 23'd0);
        a_inf  = (a_exp == 8'hff) && (a_r[22:0] == 23'd0);
        b_inf  = (b_exp == 8'hff) && (b_r[22:0] == 23'd0);
        a_nan  = (a_exp == 8'hff) && (a_r[22:0] != 23'd0);
        b_nan  = (b_exp == 8'hff) && (b_r[22:0] != 23'd0);
        a_snan = a_nan && !a_r[22];
        b_snan = b_nan && !b_r[22];
        man_a  = {a_exp != 8'd0, a_r[22:0]};
        man_b  = {b_exp != 8'd0, b_r[22:0]};
        lz_a   = (a_exp == 8'd0) ? lzc24(man_a) : 5'd0;
        lz_b   = (b_exp == 8'd0) ? lzc24(man_b) : 5'd0;
        ea     = $signed({2'b00, a_exp}) + ((a_exp == 8'd0) ? 10'sd1 : 10'sd0)
                 - $signed({5'd0, lz_a});
        eb     = $signed({2'b00, b_exp}) + ((b_exp == 8'd0) ? 10'sd1 : 10'sd0)
                 - $signed({5'd0, lz_b});
        sign_n = a_r[31] ^ b_r[31];

        spec_n     = 1'b1;
        spec_nv_n  = 1'b0;
        spec_dz_n  = 1'b0;
        spec_res_n = 32'h7fc00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_nv_n = a_snan || b_snan || (a_zero && b_zero) || (a_inf && b_inf);
        end else if (a_inf) begin
            spec_res_n = {sign_n, 31'h7f800000};
        end else if (b_zero) begin
            spec_res_n = {sign_n, 31'h7f800000};
            spec_dz_n  = 1'b1;
        end else if (b_inf || a_zero) begin
            spec_res_n = {sign_n, 31'd0};
        end else begin
            spec_n = 1'b0;
        end
    end

    // Restoring divider step(s) for one DIV cycle
    always_comb begin
        rem_n = rem;
        q_n   = q;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_n >= {1'b0, mb}) begin
                rem_n = rem_n - {1'b0, mb};
                q_n   = {q_n[25:0], 1'b1};
            end else begin
                q_n   = {q_n[25:0], 1'b0};
            end
            rem_n = {rem_n[23:0], 1'b0};
        end
    end

    // Normalise, denormalise, round and pack
    logic [26:0]       qn, qs, mask;
    logic signed [9:0] en;
    logic [9:0]        ef, sh_full, fe;
    logic [4:0]        sh;
    logic [23:0]       m24;
    logic [24:0]       m25;
    logic              lost, rbit, st, inc, inexact, ovf;
    logic [31:0]       res_n;
    logic [4:0]        flags_n;

    always_comb begin
        qn      = q[26] ? q : {q[25:0], 1'b0};
        en      = q[26] ? exp_q : exp_q - 10'sd1;
        sh_full = $unsigned(10'sd1 - en);
        sh      = 5'd0;
        ef      = $unsigned(en);
        if (en <= 10'sd0) begin
            sh = (sh_full > 10'd26) ? 5'd26 : sh_full[4:0];
            ef = 10'd0;
        end
        mask    = ~(27'h7ffffff << sh);
        lost    = |(qn & mask);
        qs      = qn >> sh;
        m24     = qs[26:3];
        rbit    = qs[2];
        st      = (|qs[1:0]) | lost | (rem != 25'd0);
        inexact = rbit | st;
        case (rm_r)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = inexact & sign;
            RM_RUP:  inc = inexact & ~sign;
            RM_RMM:  inc = rbit;
            default: inc = rbit & (st | m24[0]);
        endcase
        m25 = {1'b0, m24} + 25'(inc);
        fe  = ef + 10'(m25[24]) + 10'((ef == 10'd0) && m25[23]);
        ovf = fe >= 10'd255;

        res_n = {sign, fe[7:0], m25[24] ? m25[23:1] : m25[22:0]};
        if (ovf) begin
            case (rm_r)
                RM_RTZ:  res_n = {sign, 31'h7f7fffff};
                RM_RDN:  res_n = sign ? {sign, 31'h7f800000} : {sign, 31'h7f7fffff};
                RM_RUP:  res_n = sign ? {sign, 31'h7f7fffff} : {sign, 31'h7f800000};
                default: res_n = {sign, 31'h7f800000};
            endcase
        end
        flags_n = {2'b00, ovf, (fe == 10'd0) & inexact, inexact | ovf};
        if (spec) begin
            res_n   = spec_res;
            flags_n = {spec_nv, spec_dz, 3'b000};
        end
    end

    // State and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= 32'd0;
            {nv, dz, of, uf, nx} <= 5'd0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == S_IDLE);
            out_valid <= (state_nxt == S_DONE);
            if (state == S_ROUND) begin
                result <= res_n;
                {nv, dz, of, uf, nx} <= flags_n;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= 32'd0;  b_r <= 32'd0;  rm_r <= 3'd0;
            sign <= 1'b0;  exp_q <= 10'sd0;  mb <= 24'd0;
            rem <= 25'd0;  q <= 27'd0;  cnt <= 5'd0;
            spec <= 1'b0;  spec_nv <= 1'b0;  spec_dz <= 1'b0;  spec_res <= 32'd0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    a_r  <= a;
                    b_r  <= b;
                    rm_r <= rm;
                end
                S_PREP: begin
                    sign     <= sign_n;
                    exp_q    <= ea - eb + 10'sd127;
                    mb       <= man_b << lz_b;
                    rem      <= {1'b0, man_a << lz_a};
                    q        <= 27'd0;
                    cnt      <= 5'd0;
                    spec     <= spec_n;
                    spec_nv  <= spec_nv_n;
                    spec_dz  <= spec_dz_n;
                    spec_res <= spec_res_n;
                end
                S_DIV: begin
                    rem <= rem_n;
                    q   <= q_n;
                    cnt <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
